// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-driven round-robin signal controller for a
// four-approach intersection (N=0, E=1, S=2, W=3). Each green is followed by
// yellow and an all-red clearance. Light encoding: red=00, yellow=01, green=10.
// Optional build macro PREEMPT_PHASE_EN adds emergency-vehicle preemption
// through the preempt / preempt_dir ports.
//
// state  | meaning
// FLASH  | post-reset, all four approaches yellow for YELLOW_T ticks
// ALLRED | clearance interval, all red for ALLRED_T ticks, then pick next
// IDLE   | no demand, all red, waits for any req bit without a tick
// GREEN  | current approach green until demand elsewhere ends its turn
// YELLOW | current approach yellow for YELLOW_T ticks
module traffic_phase_scheduler #(
  parameter int TICK_DIV  = 50000000,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef PREEMPT_PHASE_EN
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
`endif
  output logic [1:0] north,
  output logic [1:0] east,
  output logic [1:0] south,
  output logic [1:0] west,
  output logic [3:0] grant,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] YEL_C  = 8'(YELLOW_T);
  localparam logic [7:0] AR_C   = 8'(ALLRED_T);
  localparam logic [7:0] GMIN_C = 8'(GREEN_MIN);
  localparam logic [7:0] GMAX_C = 8'(GREEN_MAX);

  localparam logic [2:0] S_FLASH  = 3'd0;
  localparam logic [2:0] S_ALLRED = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_GREEN  = 3'd3;
  localparam logic [2:0] S_YELLOW = 3'd4;

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;

  logic [PW-1:0] prescale;
  logic          tick;
  logic [2:0]    state, state_nxt;
  logic [7:0]    timer, timer_inc;
  logic [1:0]    cur, cur_nxt, ptr, ptr_nxt;
  logic [1:0]    winner;
  logic          any_req, other;
  logic [3:0]    cur_oh;
  logic          pre_on;
  logic [1:0]    pre_dir;
  logic [1:0]    lights [4];

`ifdef PREEMPT_PHASE_EN
  assign pre_on  = preempt;
  assign pre_dir = preempt_dir;
`else
  assign pre_on  = 1'b0;
  assign pre_dir = 2'd0;
`endif

  // Free-running tick prescaler, wraps at TICK_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 prescale <= '0;
    else if (prescale == PRE_LAST) prescale <= '0;
    else                        prescale <= prescale + PW'(1);
  end

  assign tick = (prescale == PRE_LAST);

  // Thresholds are judged on the count this tick brings the timer to, so a
  // phase of T ticks ends exactly on its T-th tick edge.
  assign timer_inc = (tick && (timer != 8'hff)) ? timer + 8'd1 : timer;

  assign cur_oh  = 4'b0001 << cur;
  assign any_req = |req;
  assign other   = |(req & ~cur_oh);

  // Round-robin search starting just after ptr; ptr itself is checked last
  always_comb begin
    winner = ptr;
    for (int k = 3; k >= 1; k--) begin
      if (req[ptr + 2'(k)]) winner = ptr + 2'(k);
    end
  end

  // Next-state, current approach and pointer selection
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    ptr_nxt   = ptr;
    case (state)
      S_FLASH:  if (timer_inc == YEL_C) state_nxt = S_ALLRED;
      S_ALLRED: if (timer_inc == AR_C) begin
                  if (pre_on) begin
                    state_nxt = S_GREEN;
                    cur_nxt   = pre_dir;
                    ptr_nxt   = pre_dir;
                  end else if (any_req) begin
                    state_nxt = S_GREEN;
                    cur_nxt   = winner;
                    ptr_nxt   = winner;
                  end else begin
                    state_nxt = S_IDLE;
                  end
                end
      S_IDLE:   if (pre_on) begin
                  state_nxt = S_GREEN;
                  cur_nxt   = pre_dir;
                  ptr_nxt   = pre_dir;
                end else if (any_req) begin
                  state_nxt = S_GREEN;
                  cur_nxt   = winner;
                  ptr_nxt   = winner;
                end
      S_GREEN:  if (pre_on) begin
                  if (cur != pre_dir) state_nxt = S_YELLOW;
                end else if (other && (timer_inc >= GMIN_C) &&
                             (!req[cur] || (timer_inc >= GMAX_C))) begin
                  state_nxt = S_YELLOW;
                end
      S_YELLOW: if (timer_inc == YEL_C) state_nxt = S_ALLRED;
      default:  state_nxt = S_FLASH;
    endcase
  end

  // State, approach, pointer and phase timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FLASH;
      timer <= 8'd0;
      cur   <= 2'd0;
      ptr   <= 2'd3;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      ptr   <= ptr_nxt;
      timer <= (state_nxt != state) ? 8'd0 : timer_inc;
    end
  end

  // Light, grant and busy decode from the registered state
  always_comb begin
    for (int i = 0; i < 4; i++) lights[i] = L_RED;
    grant = 4'b0000;
    busy  = (state != S_IDLE);
    case (state)
      S_FLASH:  for (int i = 0; i < 4; i++) lights[i] = L_YEL;
      S_GREEN:  begin
                  lights[cur] = L_GRN;
                  grant       = cur_oh;
                end
      S_YELLOW: begin
                  lights[cur] = L_YEL;
                  grant       = cur_oh;
                end
      default:  ;
    endcase
  end

  assign north = lights[0];
  assign east  = lights[1];
  assign south = lights[2];
  assign west  = lights[3];

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios plus a
// randomized demand run, compared every cycle against a phase-level model.
module tb_traffic_phase_scheduler;

  localparam int TD = 4;
  localparam int GM = 3;
  localparam int GX = 6;
  localparam int YT = 2;
  localparam int AT = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] north, east, south, west;
  logic [3:0] grant;
  logic       busy;
`ifdef PREEMPT_PHASE_EN
  logic       preempt = 1'b0;
  logic [1:0] preempt_dir = 2'd0;
`endif

  traffic_phase_scheduler #(
    .TICK_DIV (TD),
    .GREEN_MIN(GM),
    .GREEN_MAX(GX),
    .YELLOW_T (YT),
    .ALLRED_T (AT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
`ifdef PREEMPT_PHASE_EN
    .preempt    (preempt),
    .preempt_dir(preempt_dir),
`endif
    .north      (north),
    .east       (east),
    .south      (south),
    .west       (west),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Phase-level reference model
  typedef enum {P_GREEN, P_AMBER, P_CLEAR, P_REST, P_FLASH} phase_t;
  phase_t m_ph;
  int     m_ticks;
  int     m_cur;
  int     m_ptr;
  int     m_cyc;

  task automatic chk(input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", what, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = P_FLASH; m_ticks = 0; m_cur = 0; m_ptr = 3; m_cyc = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    bit     tk;
    int     reached;
    phase_t nx;
    bit     others;
    tk = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    reached = m_ticks + (tk ? 1 : 0);
    if (reached > 255) reached = 255;
    nx = m_ph;
    case (m_ph)
      P_FLASH: if (reached >= YT) nx = P_CLEAR;
      P_CLEAR: if (reached >= AT) nx = (r != 4'b0) ? P_GREEN : P_REST;
      P_REST:  if (r != 4'b0) nx = P_GREEN;
      P_GREEN: begin
        others = 1'b0;
        for (int i = 0; i < 4; i++) if (i != m_cur && r[i]) others = 1'b1;
        if (others && reached >= GM && (!r[m_cur] || reached >= GX)) nx = P_AMBER;
      end
      P_AMBER: if (reached >= YT) nx = P_CLEAR;
      default: nx = P_FLASH;
    endcase
    if (nx == P_GREEN && m_ph != P_GREEN) begin
      for (int k = 1; k <= 4; k++) begin
        if (r[(m_ptr + k) % 4]) begin
          m_cur = (m_ptr + k) % 4;
          break;
        end
      end
      m_ptr = m_cur;
    end
    m_ticks = (nx != m_ph) ? 0 : reached;
    m_ph = nx;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] el [4];
    logic [3:0] eg;
    logic       eb;
    for (int i = 0; i < 4; i++) el[i] = (m_ph == P_FLASH) ? 2'b01 : 2'b00;
    eg = 4'b0;
    eb = (m_ph != P_REST);
    if (m_ph == P_GREEN) begin el[m_cur] = 2'b10; eg[m_cur] = 1'b1; end
    if (m_ph == P_AMBER) begin el[m_cur] = 2'b01; eg[m_cur] = 1'b1; end
    chk({tag, ":north"}, 32'(north), 32'(el[0]));
    chk({tag, ":east"},  32'(east),  32'(el[1]));
    chk({tag, ":south"}, 32'(south), 32'(el[2]));
    chk({tag, ":west"},  32'(west),  32'(el[3]));
    chk({tag, ":grant"}, 32'(grant), 32'(eg));
    chk({tag, ":busy"},  32'(busy),  32'(eb));
  endtask

  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_all("cycle");
  endtask

  function automatic logic [1:0] light_of(input int d);
    case (d)
      0: return north;
      1: return east;
      2: return south;
      default: return west;
    endcase
  endfunction

  task automatic run_until_light(input logic [3:0] r, input int d, input logic [1:0] v,
                                 input int budget, output int n);
    n = 0;
    do begin
      cycle(r);
      n++;
    end while (light_of(d) !== v && n < budget);
  endtask

  initial begin
    int n;
    int glitches;
    logic [3:0] r;
    int hold;

    // Reset state
    rst_n = 1'b0;
    req   = 4'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Flash 8 cycles, all-red 4 cycles, then idle
    run_until_light(4'b0000, 0, 2'b00, 20, n);
    chk("flash_len", n, 8);
    n = 0;
    do begin cycle(4'b0000); n++; end while (busy !== 1'b0 && n < 20);
    chk("allred_len", n, 4);
    chk("idle_grant", 32'(grant), 0);

    // Idle to east green with no tick wait
    cycle(4'b0010);
    chk("east_green_now", 32'(east), 32'(2'b10));
    chk("east_grant", 32'(grant), 32'(4'b0010));
    run_until_light(4'b0001, 1, 2'b01, 40, n);
    chk("east_min_green", n, 11);
    run_until_light(4'b0001, 0, 2'b10, 40, n);
    chk("north_after_clear", n, 12);

    // All approaches requesting: strict rotation at GREEN_MAX
    run_until_light(4'b1111, 1, 2'b10, 100, n);
    chk("east_green_rr", 32'(east), 32'(2'b10));
    for (int d = 1; d <= 4; d++) begin
      run_until_light(4'b1111, d % 4, 2'b01, 60, n);
      chk("rr_green_len", n, 24);
      run_until_light(4'b1111, d % 4, 2'b00, 30, n);
      chk("rr_yellow_len", n, 8);
      run_until_light(4'b1111, (d + 1) % 4, 2'b10, 30, n);
      chk("rr_allred_len", n, 4);
    end

    // Lone south demand rests in green through timer saturation
    run_until_light(4'b0100, 2, 2'b10, 100, n);
    chk("south_green", 32'(south), 32'(2'b10));
    glitches = 0;
    for (int i = 0; i < 270 * TD; i++) begin
      cycle(4'b0100);
      if (south !== 2'b10) glitches++;
    end
    chk("south_rest_glitches", glitches, 0);

    // Saturated timer yields at once when others wait
    run_until_light(4'b1111, 2, 2'b01, 5, n);
    chk("south_yield", n, 1);

    // Async reset mid-yellow
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_until_light(4'b0000, 0, 2'b00, 20, n);
    chk("flash_len_again", n, 8);

    // Randomized demand
    n = 0;
    while (n < 1500) begin
      r    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 30);
      for (int j = 0; j < hold; j++) cycle(r);
      n += hold;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
